imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single combinational read port of the instruction memory between two requesters:
//   - IF: instruction fetch, default-priority.
//   - DBG: debug/monitor reader for program dump and breakpoint inspection.
//  Sits between the IF stage/debug unit and the instruction memory.
//  Grants one requester per cycle and registers the read data, returning it one cycle later.
//  Starvation guard forces a DBG grant after a bounded number of denied cycles.
// PARAMETERS
//  ADDR_W    32  byte-address width of both requesters and the memory port
//  DATA_W    32  instruction word width
//  MAX_WAIT  4   consecutive denied DBG-request cycles before DBG is forced to win (>=1)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous reset, active-high
//  i_if_req       in   1       IF read request (level, sampled each cycle)
//  i_if_addr      in   ADDR_W  IF byte address
//  o_if_gnt       out  1       IF granted this cycle (combinational)
//  o_if_rvalid    out  1       IF read data valid (registered, cycle after grant)
//  o_if_rdata     out  DATA_W  IF read data
//  o_if_misalign  out  1       with o_if_rvalid: granted address had addr[1:0]!=0
//  i_dbg_req      in   1       DBG read request
//  i_dbg_addr     in   ADDR_W  DBG byte address
//  o_dbg_gnt      out  1       DBG granted this cycle (combinational)
//  o_dbg_rvalid   out  1       DBG read data valid (registered)
//  o_dbg_rdata    out  DATA_W  DBG read data
//  o_mem_addr     out  ADDR_W  address to instruction memory (memory indexes word = addr>>2)
//  i_mem_data     in   DATA_W  combinational read data from instruction memory
// BEHAVIOUR
//  Reset (async, rst=1): all registered outputs 0, wait_cnt=0, owner=NONE; pending rvalid dropped.
//  Arbitration, combinational each cycle:
//   - Only one request: that requester is granted.
//   - Both request, wait_cnt<MAX_WAIT: IF wins.
//   - Both request, wait_cnt==MAX_WAIT: DBG wins.
//   - No request: no grant, o_mem_addr=0.
//  o_mem_addr = granted requester's address unmodified; alignment is not corrected.
//  wait_cnt (clog2(MAX_WAIT+1) bits), updated at posedge:
//   - DBG requested and not granted: wait_cnt+1, saturating at MAX_WAIT.
//   - DBG granted, or i_dbg_req=0: wait_cnt=0.
//  owner register {NONE, IF, DBG}, loaded every posedge with the winner (NONE if no grant).
//  rdata register: captures i_mem_data at the posedge ending the grant cycle; misalign flag captured likewise.
//  Response, cycle N+1 after grant in cycle N:
//   - owner=IF:  o_if_rvalid=1, o_if_rdata=rdata.
//   - owner=DBG: o_dbg_rvalid=1, o_dbg_rdata=rdata.
//   - rvalid is a one-cycle pulse per grant.
//   - rdata outputs hold their last value when rvalid=0.
//  Latency: grant to data = 1 cycle. Throughput: 1 read/cycle total.
//  Back-to-back grants to the same requester produce consecutive rvalid pulses.
//  Requester may change address/req every cycle; no request is queued — a denied requester must hold req.
//  o_if_misalign/o_dbg_misalign: DBG has no misalign output; its misaligned reads return word addr>>2 silently.
//  Reset asserted mid-transaction: rvalid of the in-flight grant never appears.
//  First grant is possible in the first cycle after rst deasserts.
// TESTING
//  1. IF-only stream: req=1, addr 0,4,8 in consecutive cycles
//     -> o_if_gnt=1 each cycle; o_if_rvalid on cycles 1..3 with mem[0],mem[1],mem[2].
//  2. Both request continuously, MAX_WAIT=4
//     -> IF granted cycles 0-3, DBG granted cycle 4, wait_cnt back to 0, IF granted cycles 5-8, DBG cycle 9.
//  3. DBG-only request, addr 0x40 -> o_dbg_gnt=1 same cycle; o_dbg_rvalid=1 next cycle with mem[16]; o_if_rvalid stays 0.
//  4. IF addr 0x6 -> o_mem_addr=0x6; next cycle o_if_rvalid=1, o_if_misalign=1, data=mem[1].
//  5. DBG denied 2 cycles, drops req 1 cycle, re-requests with IF busy
//     -> wait_cnt restarts from 0; DBG granted only after 4 further denied cycles.
//  6. rst asserted the cycle after an IF grant -> o_if_rvalid=0 immediately and after release; wait_cnt=0.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Two-requester (IF / DBG) arbiter for the single combinational read port of the instruction memory.
// Latency: grant is combinational in cycle N, read data returned registered in cycle N+1.
// Backpressure: none queued; a denied requester must hold its request. DBG is forced to win after MAX_WAIT denials.
//
// Ports:
//   clk, rst                          clock (rising edge), asynchronous active-high reset
//   i_if_req/i_if_addr                IF fetch request and byte address
//   o_if_gnt                          IF granted this cycle (combinational)
//   o_if_rvalid/o_if_rdata            IF read response, one-cycle pulse the cycle after the grant
//   o_if_misalign                     with o_if_rvalid: granted IF address had addr[1:0] != 0
//   i_dbg_req/i_dbg_addr              DBG read request and byte address
//   o_dbg_gnt                         DBG granted this cycle (combinational)
//   o_dbg_rvalid/o_dbg_rdata          DBG read response, one-cycle pulse the cycle after the grant
//   o_mem_addr/i_mem_data             memory read port (memory indexes word addr>>2)
module imem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_misalign,
    input  logic              i_dbg_req,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic              o_dbg_gnt,
    output logic              o_dbg_rvalid,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              misalign_q, misalign_d;
    logic              if_win, dbg_win;

    // IF has default priority; DBG wins when alone or once it has been
    // denied MAX_WAIT consecutive cycles.
    always_comb begin
        dbg_win = i_dbg_req && (!i_if_req || (wait_cnt_q == WAIT_MAX));
        if_win  = i_if_req && !dbg_win;
    end

    always_comb begin
        o_mem_addr = '0;
        if (if_win) begin
            o_mem_addr = i_if_addr;
        end else if (dbg_win) begin
            o_mem_addr = i_dbg_addr;
        end
    end

    assign o_if_gnt  = if_win;
    assign o_dbg_gnt = dbg_win;

    // Next-state: denial streak counter, owner of the in-flight read, and
    // per-requester data registers that hold their value between pulses.
    always_comb begin
        wait_cnt_d  = '0;
        owner_d     = OWN_NONE;
        if_rdata_d  = if_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        misalign_d  = 1'b0;

        if (i_dbg_req && !dbg_win) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
        end

        if (if_win) begin
            owner_d    = OWN_IF;
            if_rdata_d = i_mem_data;
            misalign_d = (i_if_addr[1:0] != 2'b00);
        end else if (dbg_win) begin
            owner_d     = OWN_DBG;
            dbg_rdata_d = i_mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            wait_cnt_q  <= '0;
            if_rdata_q  <= '0;
            dbg_rdata_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            if_rdata_q  <= if_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            misalign_q  <= misalign_d;
        end
    end

    // The owner register doubles as the response-valid pulse: it is reloaded
    // every cycle, so each grant produces exactly one rvalid cycle.
    assign o_if_rvalid   = (owner_q == OWN_IF);
    assign o_dbg_rvalid  = (owner_q == OWN_DBG);
    assign o_if_rdata    = if_rdata_q;
    assign o_dbg_rdata   = dbg_rdata_q;
    assign o_if_misalign = misalign_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        int          tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        dbg_req = 1'b0;
    logic [31:0] dbg_addr = '0;
    logic        o_if_gnt, o_if_rvalid, o_if_misalign;
    logic [31:0] o_if_rdata;
    logic        o_dbg_gnt, o_dbg_rvalid;
    logic [31:0] o_dbg_rdata;
    logic [31:0] o_mem_addr;
    logic [31:0] mem_data;

    logic [31:0] mem [256];
    exp_t        if_q[$];
    exp_t        dbg_q[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          streak = 0;
    logic [31:0] last_if = '0;
    logic [31:0] last_dbg = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int idx;
        idx = int'((a >> 2) & 32'h0000_00FF);
        return mem[idx];
    endfunction

    assign mem_data = mem_word(o_mem_addr);

    imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_if_req     (if_req),
        .i_if_addr    (if_addr),
        .o_if_gnt     (o_if_gnt),
        .o_if_rvalid  (o_if_rvalid),
        .o_if_rdata   (o_if_rdata),
        .o_if_misalign(o_if_misalign),
        .i_dbg_req    (dbg_req),
        .i_dbg_addr   (dbg_addr),
        .o_dbg_gnt    (o_dbg_gnt),
        .o_dbg_rvalid (o_dbg_rvalid),
        .o_dbg_rdata  (o_dbg_rdata),
        .o_mem_addr   (o_mem_addr),
        .i_mem_data   (mem_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One request cycle: inputs change just after the edge, the reference model
    // decides the winner from the denial streak, and the expected response is queued.
    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
        logic        w_if, w_dbg;
        logic [31:0] ea;
        @(posedge clk);
        #1;
        if_req   = ir;
        if_addr  = ia;
        dbg_req  = dr;
        dbg_addr = da;
        w_dbg = dr && (!ir || streak >= MAX_WAIT);
        w_if  = ir && !w_dbg;
        ea    = w_if ? ia : (w_dbg ? da : 32'h0);
        if (w_if)  if_q.push_back('{data: mem_word(ia), mis: (ia % 4) != 0, tag: cyc});
        if (w_dbg) dbg_q.push_back('{data: mem_word(da), mis: 1'b0, tag: cyc});
        if (dr && !w_dbg) streak = (streak < MAX_WAIT) ? streak + 1 : streak;
        else              streak = 0;
        #3;
        check("if_gnt",   {31'b0, o_if_gnt},  {31'b0, w_if});
        check("dbg_gnt",  {31'b0, o_dbg_gnt}, {31'b0, w_dbg});
        check("mem_addr", o_mem_addr, ea);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        if_req  = 1'b0;
        dbg_req = 1'b0;
        streak  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Response monitor: each queued grant must appear exactly one cycle later.
    always @(negedge clk) begin
        if (rst) begin
            if_q.delete();
            dbg_q.delete();
            last_if  = '0;
            last_dbg = '0;
            check("rst_if_rvalid",  {31'b0, o_if_rvalid},   32'h0);
            check("rst_dbg_rvalid", {31'b0, o_dbg_rvalid},  32'h0);
            check("rst_if_rdata",   o_if_rdata,  32'h0);
            check("rst_dbg_rdata",  o_dbg_rdata, 32'h0);
            check("rst_misalign",   {31'b0, o_if_misalign}, 32'h0);
        end else begin
            while (if_q.size() > 0 && if_q[0].tag < cyc - 1) begin
                tests++;
                fails++;
                $display("FAIL if_rvalid_missing: grant of cyc %0d never returned, got none, expected a pulse", if_q[0].tag);
                void'(if_q.pop_front());
            end
            if (if_q.size() > 0 && if_q[0].tag == cyc - 1) begin
                exp_t e;
                e = if_q.pop_front();
                check("if_rvalid",   {31'b0, o_if_rvalid},   32'h1);
                check("if_rdata",    o_if_rdata, e.data);
                check("if_misalign", {31'b0, o_if_misalign}, {31'b0, e.mis});
                last_if = e.data;
            end else begin
                check("if_rvalid_idle", {31'b0, o_if_rvalid}, 32'h0);
                check("if_rdata_hold",  o_if_rdata, last_if);
            end

            while (dbg_q.size() > 0 && dbg_q[0].tag < cyc - 1) begin
                tests++;
                fails++;
                $display("FAIL dbg_rvalid_missing: grant of cyc %0d never returned, got none, expected a pulse", dbg_q[0].tag);
                void'(dbg_q.pop_front());
            end
            if (dbg_q.size() > 0 && dbg_q[0].tag == cyc - 1) begin
                exp_t e;
                e = dbg_q.pop_front();
                check("dbg_rvalid", {31'b0, o_dbg_rvalid}, 32'h1);
                check("dbg_rdata",  o_dbg_rdata, e.data);
                last_dbg = e.data;
            end else begin
                check("dbg_rvalid_idle", {31'b0, o_dbg_rvalid}, 32'h0);
                check("dbg_rdata_hold",  o_dbg_rdata, last_dbg);
            end
        end
    end

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 255)) << 2;
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // IF-only stream of consecutive words
        drive(1'b1, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 32'h4, 1'b0, 32'h0);
        drive(1'b1, 32'h8, 1'b0, 32'h0);

        // Both requesting continuously: DBG wins every fifth cycle
        for (int i = 0; i < 10; i++) drive(1'b1, 32'(i * 4), 1'b1, 32'h100 + 32'(i * 4));

        // DBG alone, then a misaligned IF read
        drive(1'b0, 32'h0, 1'b1, 32'h40);
        drive(1'b1, 32'h6, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 32'h43);

        // DBG denied twice, drops req, then restarts its streak from zero
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 32'h20, 1'b1, 32'h80);
        drive(1'b1, 32'h24, 1'b1, 32'h80);
        drive(1'b1, 32'h28, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) drive(1'b1, 32'h30 + 32'(i * 4), 1'b1, 32'h84);

        // Reset the cycle after an IF grant drops the pending response
        drive(1'b1, 32'h10, 1'b0, 32'h0);
        do_reset();
        drive(1'b1, 32'h14, 1'b1, 32'h90);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 3) != 0, rnd_addr(),
                      $urandom_range(0, 2) == 0 || (i % 64) > 48, rnd_addr());
            end
        end

        drive(1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("if_q_drained",  32'(if_q.size()),  32'h0);
        check("dbg_q_drained", 32'(dbg_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got no end, expected completion");
        $fatal(1, "timeout");
    end

endmodule
